// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep tester: FSM encoding, count width,
// err_vec bit positions and a small population-count helper.
package gate_sweep_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t HOLD_S = 2'd1;
    localparam state_t CHECK  = 2'd2;
    localparam state_t DONE   = 2'd3;

    localparam int unsigned ERR_W  = 8;
    localparam int unsigned GATE_N = 5;

    localparam int unsigned IDX_ANOT   = 0;
    localparam int unsigned IDX_ABNAND = 1;
    localparam int unsigned IDX_ABAND  = 2;
    localparam int unsigned IDX_ABOR   = 3;
    localparam int unsigned IDX_ABXOR  = 4;

    function automatic logic [2:0] popcount5(input logic [GATE_N-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < GATE_N; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gate_sweep_ref.sv
// Combinational golden model: expected response of each gate under test
// for the current stimulus pair.
module gate_ref
    import gate_sweep_pkg::*;
(
    input  logic              a_i,
    input  logic              b_i,
    output logic [GATE_N-1:0] expected_o
);

    always_comb begin
        expected_o             = '0;
        expected_o[IDX_ANOT]   = ~a_i;
        expected_o[IDX_ABNAND] = ~(a_i & b_i);
        expected_o[IDX_ABAND]  = a_i & b_i;
        expected_o[IDX_ABOR]   = a_i | b_i;
        expected_o[IDX_ABXOR]  = a_i ^ b_i;
    end

endmodule

// File: rtl/gate_sweep.sv
// Sweeps {b,a} through 00,01,10,11, holds each vector, then checks five gate
// responses against gate_ref and accumulates saturating / sticky error status.
module gate_sweep
    import gate_sweep_pkg::*;
#(
    parameter int unsigned HOLD   = 4,
    parameter int unsigned PASSES = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             anot,
    input  logic             abnand,
    input  logic             aband,
    input  logic             abor,
    input  logic             abxor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [4:0]       err_vec
);

    localparam int unsigned HOLD_EFF  = (HOLD == 0) ? 1 : HOLD;
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_EFF - 1);
    localparam logic [3:0]  PASS_LAST = 4'(PASSES - 1);

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         hcnt_q, hcnt_d;
    logic [3:0]         pcnt_q, pcnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [GATE_N-1:0]  ev_q, ev_d;

    logic [GATE_N-1:0]  expected;
    logic [GATE_N-1:0]  response;
    logic [GATE_N-1:0]  mism;
    logic [ERR_W:0]     err_sum;
    logic [ERR_W-1:0]   err_sat;

    gate_ref u_ref (
        .a_i        (idx_q[0]),
        .b_i        (idx_q[1]),
        .expected_o (expected)
    );

    // Responses only matter during CHECK; masking here keeps X values out.
    always_comb begin
        response             = '0;
        response[IDX_ANOT]   = anot;
        response[IDX_ABNAND] = abnand;
        response[IDX_ABAND]  = aband;
        response[IDX_ABOR]   = abor;
        response[IDX_ABXOR]  = abxor;
        mism    = (state_q == CHECK) ? (response ^ expected) : '0;
        err_sum = {1'b0, err_q} + (ERR_W + 1)'(popcount5(mism));
        err_sat = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hcnt_d  = hcnt_q;
        pcnt_d  = pcnt_q;
        err_d   = err_q;
        ev_d    = ev_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = HOLD_S;
                    idx_d   = '0;
                    hcnt_d  = '0;
                    pcnt_d  = '0;
                    err_d   = '0;
                    ev_d    = '0;
                end
            end
            HOLD_S: begin
                hcnt_d = hcnt_q + 8'd1;
                if (hcnt_q == HOLD_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                err_d  = err_sat;
                ev_d   = ev_q | mism;
                hcnt_d = '0;
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = HOLD_S;
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                    if (pcnt_q == PASS_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = '0;
                        state_d = HOLD_S;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
            err_q   <= '0;
            ev_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hcnt_q  <= hcnt_d;
            pcnt_q  <= pcnt_d;
            err_q   <= err_d;
            ev_q    <= ev_d;
        end
    end

    // Stimulus comes straight from the vector index, so a/b only move when
    // the index does (on entry to HOLD_S) and hold 11 through DONE.
    assign a         = idx_q[0];
    assign b         = idx_q[1];
    assign busy      = (state_q == HOLD_S) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign pass      = done && (err_q == '0);
    assign err_count = err_q;
    assign err_vec   = ev_q;

endmodule

// File: tb/tb_gate_sweep.sv
// Bench for gate_sweep: four parameterisations driven by a table of runs
// (directed + random fault masks) checked against an arithmetic run model.
module tb_gate_sweep;

    localparam int NI = 4;

    typedef struct {
        int          inst;
        logic [19:0] fm;      // per-vector response error mask, vector v at [v*5 +: 5]
        int          mid_k;   // cycle to pulse start while busy (0 = none)
        int          abort_k; // cycle to assert reset + start (0 = none)
        int          exp_len;
        logic [7:0]  exp_ec;
        logic [4:0]  exp_ev;
        logic        exp_pass;
    } run_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start_s [NI];
    logic [4:0] resp    [NI];
    logic       a_w     [NI];
    logic       b_w     [NI];
    logic       busy_w  [NI];
    logic       done_w  [NI];
    logic       pass_w  [NI];
    logic [7:0] ec_w    [NI];
    logic [4:0] ev_w    [NI];

    int vectors = 0;
    int miscompares = 0;
    run_t tbl[$];

    gate_sweep #(.HOLD(4), .PASSES(1)) u0 (
        .clock(clk), .reset(reset), .start(start_s[0]), .a(a_w[0]), .b(b_w[0]),
        .anot(resp[0][0]), .abnand(resp[0][1]), .aband(resp[0][2]), .abor(resp[0][3]), .abxor(resp[0][4]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(ec_w[0]), .err_vec(ev_w[0]));
    gate_sweep #(.HOLD(2), .PASSES(2)) u1 (
        .clock(clk), .reset(reset), .start(start_s[1]), .a(a_w[1]), .b(b_w[1]),
        .anot(resp[1][0]), .abnand(resp[1][1]), .aband(resp[1][2]), .abor(resp[1][3]), .abxor(resp[1][4]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(ec_w[1]), .err_vec(ev_w[1]));
    gate_sweep #(.HOLD(1), .PASSES(15)) u2 (
        .clock(clk), .reset(reset), .start(start_s[2]), .a(a_w[2]), .b(b_w[2]),
        .anot(resp[2][0]), .abnand(resp[2][1]), .aband(resp[2][2]), .abor(resp[2][3]), .abxor(resp[2][4]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(ec_w[2]), .err_vec(ev_w[2]));
    gate_sweep #(.HOLD(0), .PASSES(1)) u3 (
        .clock(clk), .reset(reset), .start(start_s[3]), .a(a_w[3]), .b(b_w[3]),
        .anot(resp[3][0]), .abnand(resp[3][1]), .aband(resp[3][2]), .abor(resp[3][3]), .abxor(resp[3][4]),
        .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .err_count(ec_w[3]), .err_vec(ev_w[3]));

    function automatic int raw_hold(input int i);
        case (i)
            0: return 4;
            1: return 2;
            2: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int heff(input int i);
        return (raw_hold(i) == 0) ? 1 : raw_hold(i);
    endfunction

    function automatic int passes_of(input int i);
        case (i)
            0: return 1;
            1: return 2;
            2: return 15;
            default: return 1;
        endcase
    endfunction

    function automatic logic [4:0] gate_truth(input logic a, input logic b);
        return {a ^ b, a | b, a & b, ~(a & b), ~a};
    endfunction

    function automatic run_t mk(input int inst, input logic [19:0] fm, input int mid_k,
                                input int abort_k, input int len, input logic [7:0] ec,
                                input logic [4:0] ev, input logic ps);
        run_t r;
        r.inst = inst; r.fm = fm; r.mid_k = mid_k; r.abort_k = abort_k;
        r.exp_len = len; r.exp_ec = ec; r.exp_ev = ev; r.exp_pass = ps;
        return r;
    endfunction

    // Whole-run model: every pass sees each vector's error mask once.
    function automatic run_t model(input int inst, input logic [19:0] fm, input int mid_k);
        int sum;
        int len;
        logic [4:0] ev;
        sum = 0;
        ev = '0;
        for (int v = 0; v < 4; v++) begin
            sum += $countones(fm[v*5 +: 5]);
            ev |= fm[v*5 +: 5];
        end
        sum = sum * passes_of(inst);
        len = 4 * passes_of(inst) * (heff(inst) + 1) + 1;
        return mk(inst, fm, mid_k, 0, len, (sum > 255) ? 8'd255 : 8'(sum), ev, sum == 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < NI; i++) resp[i] = 5'($urandom);
    endtask

    function automatic logic [31:0] idle_word(input int i);
        return 32'({busy_w[i], done_w[i], pass_w[i], b_w[i], a_w[i], ec_w[i], ev_w[i]});
    endfunction

    task automatic run_one(input run_t r);
        int h;
        int v;
        logic [1:0] vb;
        logic [3:0] exp_s;
        h = heff(r.inst);
        @(negedge clk);
        scramble();
        start_s[r.inst] = 1'b1;
        @(negedge clk);
        start_s[r.inst] = 1'b0;
        check("cleared_on_start", 32'({ec_w[r.inst], ev_w[r.inst]}), 32'd0);
        for (int k = 1; k <= r.exp_len; k++) begin
            if (k == r.abort_k) begin
                reset = 1'b1;
                start_s[r.inst] = 1'b1;
                scramble();
                @(negedge clk);
                reset = 1'b0;
                start_s[r.inst] = 1'b0;
                check("abort_idle", idle_word(r.inst), 32'd0);
                return;
            end
            v = ((k - 1) / (h + 1)) % 4;
            vb = 2'(v);
            exp_s = (k < r.exp_len) ? {2'b10, vb} : 4'b0111;
            check("seq_busy_done_b_a",
                  32'({busy_w[r.inst], done_w[r.inst], b_w[r.inst], a_w[r.inst]}), 32'(exp_s));
            start_s[r.inst] = (k == r.mid_k);
            scramble();
            if (k < r.exp_len && ((k - 1) % (h + 1)) == h)
                resp[r.inst] = gate_truth(vb[0], vb[1]) ^ r.fm[v*5 +: 5];
            if (k < r.exp_len) @(negedge clk);
        end
        start_s[r.inst] = 1'b0;
        check("err_count", 32'(ec_w[r.inst]), 32'(r.exp_ec));
        check("err_vec",   32'(ev_w[r.inst]), 32'(r.exp_ev));
        check("pass",      32'(pass_w[r.inst]), 32'(r.exp_pass));
    endtask

    initial begin
        logic [19:0] fm;
        int inst;
        reset = 1'b1;
        for (int i = 0; i < NI; i++) start_s[i] = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) check("reset_state", idle_word(i), 32'd0);
        reset = 1'b0;

        tbl.push_back(mk(0, 20'd0, 0, 0, 21, 8'd0, 5'd0, 1'b1));
        tbl.push_back(mk(1, {5'b00000, 5'b10000, 5'b10000, 5'b00000}, 7, 0, 25, 8'd4, 5'b10000, 1'b0));
        tbl.push_back(mk(1, 20'd0, 0, 0, 25, 8'd0, 5'd0, 1'b1));
        tbl.push_back(mk(2, 20'hFFFFF, 0, 0, 121, 8'd255, 5'b11111, 1'b0));
        tbl.push_back(mk(3, 20'd0, 0, 0, 9, 8'd0, 5'd0, 1'b1));
        tbl.push_back(mk(0, {15'd0, 5'b11111}, 0, 12, 21, 8'd0, 5'd0, 1'b0));
        tbl.push_back(mk(0, 20'd0, 0, 0, 21, 8'd0, 5'd0, 1'b1));
        for (int n = 0; n < 12; n++) begin
            inst = $urandom_range(0, NI - 1);
            fm = ($urandom_range(0, 2) == 0) ? 20'd0 : (20'($urandom) & 20'($urandom));
            tbl.push_back(model(inst, fm, ($urandom_range(0, 1) == 1) ? $urandom_range(2, 8) : 0));
        end

        foreach (tbl[i]) run_one(tbl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gate_sweep.md
GATE_SWEEP -- requirements
Module: gate_sweep

Interface
REQ-001 Parameter HOLD, default 4: cycles each input vector is held before sampling; legal range 1..255, value 0 treated as 1.
REQ-002 Parameter PASSES, default 1: number of full 4-vector sweeps per run; legal range 1..15.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle run request; honoured only in IDLE or DONE.
REQ-006 a  output  1  stimulus bit a to gate under test.
REQ-007 b  output  1  stimulus bit b to gate under test.
REQ-008 anot, abnand, aband, abor, abxor  input  1 each  gate responses sampled by this block.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  high from run completion until next start or reset.
REQ-011 pass  output  1  valid while done; high iff err_count==0.
REQ-012 err_count  output  8  mismatch count for the current or last run.
REQ-013 err_vec  output  5  sticky per-gate error flags, bit order {abxor,abor,aband,abnand,anot}.

Function
REQ-014 FSM states: IDLE, HOLD_S, CHECK, DONE.
REQ-015 IDLE: a=b=0, busy=0, done=0; start -> HOLD_S with vector index 0, hold counter 0, pass counter 0, err_count and err_vec cleared.
REQ-016 Vector order within a pass: {b,a} = 00, 01, 10, 11; the vector changes only on the cycle the FSM enters HOLD_S.
REQ-017 HOLD_S: hold counter increments each cycle; on the cycle it equals HOLD-1, the next state is CHECK.
REQ-018 CHECK lasts exactly one cycle: each response is compared with its expected value (~a, ~(a&b), a&b, a|b, a^b) for the current a,b.
REQ-019 Each mismatching gate increments err_count by 1; up to 5 increments per CHECK cycle, applied together.
REQ-020 err_count saturates at 255 and never wraps.
REQ-021 Each mismatching gate sets its err_vec bit; bits clear only on start or reset.
REQ-022 CHECK exit, not last vector: advance the index modulo 4 and return to HOLD_S with the hold counter at 0.
REQ-023 CHECK exit after vector 11: increment the pass counter; if it equals PASSES, go to DONE, otherwise wrap the index to 0 and return to HOLD_S.
REQ-024 Cycles per run from start accepted to done high = PASSES*4*(HOLD+1) + 1.
REQ-025 DONE: busy=0, done=1, a and b hold their last values; start -> identical behaviour to a start taken in IDLE.
REQ-026 A start asserted while busy=1 is ignored, with no effect on state or counters.
REQ-027 Responses are ignored outside CHECK, including X values.
REQ-028 busy=1 exactly in HOLD_S and CHECK.

Reset
REQ-029 On reset, regardless of state, including mid-run: the FSM returns to IDLE on the next edge, with a=0, b=0, busy=0, done=0, pass=0, err_count=0, err_vec=0, and all internal counters 0.
REQ-030 When reset and start are asserted in the same cycle, reset wins.

Structure
REQ-031 A shared package holds the FSM state enumeration, the ERR_W=8 width constant, and the err_vec bit-index constants.
REQ-032 One sub-module, gate_ref: a combinational reference model mapping (a,b) to the five expected outputs; gate_sweep instantiates it once.

Verification
REQ-033 HOLD=4, PASSES=1, correct gate set, start pulse -> a,b sweep 00,01,10,11 in 4-cycle steps; done rises 21 cycles after start; pass=1; err_count=0; err_vec=0.
REQ-034 abxor tied to 0, HOLD=2, PASSES=2 -> err_count=4 (vectors 01 and 10, both passes); err_vec=5'b10000; pass=0; done after 25 cycles.
REQ-035 All five responses inverted, PASSES=15, HOLD=1 -> err_count=255 saturated (raw count 300), err_vec=5'b11111.
REQ-036 Reset asserted during the third vector -> the next cycle shows IDLE outputs with all counters 0; a following start produces a clean run with the REQ-033 result.
REQ-037 start pulsed mid-run, then again in DONE -> the first pulse is ignored and run length is unchanged; the second pulse restarts the run with err_count and err_vec cleared.
REQ-038 HOLD=0 -> behaviour identical to HOLD=1: each vector held 1 cycle, and done rises 9 cycles after start.
